uart_tx_fifo: RTL

Buffered UART transmitter for the board's serial link: accepts bytes from on-chip logic via a single-cycle strobe, queues them in a small FIFO, and serialises them onto `txs` as 8N1 frames. It is the send side for any block that produces more than one byte at a time (status messages, echo bursts), so producers never wait on a per-byte busy handshake.

---
 rtl/uart_tx_fifo.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serialiser.
// Latency: a byte written into an idle, empty block drives txs low on the following edge.
// Backpressure: none to the producer; writes that arrive while full are dropped and flagged in tx_ovf.

// Byte queue: count-based full/empty, pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible at rd_dat one edge after the push.
// Backpressure: wr_rdy low when full; pushes while full are ignored by the queue.
module uart_tx_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       wr_rdy,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Full/empty come from the occupancy count so wrap-around never aliases.
  assign wr_rdy = (count != CW'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_rdy & rd_vld;
  assign rd_dat = mem[rd_ptr];

  // Storage array carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module uart_tx_fifo #(
  parameter int CLK_FREQ = 24000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [7:0]              tx_data,
  input  logic                    tx_data_en,
  input  logic                    ovf_clr,
  output logic                    txs,
  output logic                    tx_full,
  output logic                    tx_busy,
  output logic [$clog2(DEPTH):0]  tx_count,
  output logic                    tx_ovf
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          txs_n;
  logic          baud_end;
  logic          pop;
  logic          fifo_vld;
  logic          fifo_rdy;
  logic [7:0]    fifo_dat;
  logic          drop;

  uart_tx_fifo_buf #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_vld (tx_data_en),
    .wr_dat (tx_data),
    .wr_rdy (fifo_rdy),
    .rd_rdy (pop),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_dat),
    .count  (tx_count)
  );

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign tx_full  = ~fifo_rdy;
  // A write is judged against the pre-edge fill level, so a same-edge pop cannot rescue it.
  assign drop     = tx_data_en & ~fifo_rdy;
  assign tx_busy  = (state != S_IDLE) | (tx_count != '0);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: each bit phase lasts one full baud period; stop chains straight into start.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (fifo_vld) state_n = S_START;
      S_START: if (baud_end) state_n = S_DATA;
      S_DATA:  if (baud_end && (bit_idx == 3'd7)) state_n = S_STOP;
      S_STOP:  if (baud_end) state_n = fifo_vld ? S_START : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs: pop decision, next shifter contents and the next registered line level.
  always_comb begin
    pop     = fifo_vld & ((state == S_IDLE) | ((state == S_STOP) & baud_end));
    shift_n = shift;
    if (pop) begin
      shift_n = fifo_dat;
    end else if ((state == S_DATA) && baud_end) begin
      shift_n = {1'b0, shift[7:1]};
    end
    case (state_n)
      S_START: txs_n = 1'b0;
      S_DATA:  txs_n = shift_n[0];
      default: txs_n = 1'b1;
    endcase
  end

  // Baud timing, bit index, shifter and the glitch-free line register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      txs      <= 1'b1;
    end else begin
      if (pop || baud_end || (state == S_IDLE)) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
      if ((state == S_START) && baud_end) begin
        bit_idx <= 3'd0;
      end else if ((state == S_DATA) && baud_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
      shift <= shift_n;
      txs   <= txs_n;
    end
  end

  // Sticky overflow flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_ovf <= 1'b0;
    end else if (drop) begin
      tx_ovf <= 1'b1;
    end else if (ovf_clr) begin
      tx_ovf <= 1'b0;
    end
  end

endmodule
